// File: rtl/maj_pkg.sv
// maj_pkg: shared constants and helpers for the threshold voter family.
//   maj_cw(n)  : width needed to hold a count of 0..n, i.e. $clog2(n+1)
//   MAJ_N_DEF  : default number of voters (the classic 9-input cell)
//   MAJ_G_DEF  : default first-stage group width
package maj_pkg;

    localparam int MAJ_N_DEF = 9;
    localparam int MAJ_G_DEF = 3;

    function automatic int maj_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : maj_pkg

// File: rtl/maj_vote_pipe_popcnt_grp.sv
// popcnt_grp: purely combinational population count of a G-bit slice.
//   G      : slice width (>= 1)
//   bits   : input slice
//   count  : number of ones in bits, width maj_cw(G)
module popcnt_grp
    import maj_pkg::*;
#(
    parameter int G = MAJ_G_DEF,
    localparam int GW = maj_cw(G)
) (
    input  logic [G-1:0]  bits,
    output logic [GW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < G; i++) begin
            count = count + GW'(bits[i]);
        end
    end

endmodule : popcnt_grp

// File: rtl/maj_vote_pipe.sv
// maj_vote_pipe: two-stage pipelined threshold voter with valid/ready stream.
//   Stage 1 registers per-group popcounts and the threshold; stage 2
//   registers the summed count, the decision count >= thr and a tie flag.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_ready depends only on state
//                         and out_ready
//   in_votes [N-1:0]    : vote vector, bit i = voter i
//   in_thr   [CW-1:0]   : threshold for this transaction
//   out_valid/out_ready : output handshake
//   out_count [CW-1:0]  : popcount of the accepted vector
//   out_x               : out_count >= thr (unsigned, full width)
//   out_tie             : N even and 2*out_count == N
module maj_vote_pipe
    import maj_pkg::*;
#(
    parameter int N = MAJ_N_DEF,
    parameter int G = MAJ_G_DEF,
    localparam int CW = maj_cw(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_votes,
    input  logic [CW-1:0] in_thr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_x,
    output logic          out_tie
);

    localparam int NG  = (N + G - 1) / G;
    localparam int GW  = maj_cw(G);
    localparam int CW1 = CW + 1;

    // Single global enable: the whole pipe moves only when the output
    // register is empty or being drained this cycle.
    logic adv;

    logic [GW-1:0] grp_cnt [NG];

    logic          s1_valid_reg;
    logic [GW-1:0] s1_cnt_reg [NG];
    logic [CW-1:0] s1_thr_reg;

    logic          out_valid_reg;
    logic [CW-1:0] out_count_reg;
    logic          out_x_reg;
    logic          out_tie_reg;

    logic [CW-1:0] sum_next;
    logic [CW:0]   dbl_next;
    logic          x_next;
    logic          tie_next;

    assign adv      = !out_valid_reg || out_ready;
    assign in_ready = adv;

    // Stage 1 grouping; bits past N in the last group are tied to 0 so a
    // short remainder group counts correctly.
    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            logic [G-1:0] slice;
            for (genvar gj = 0; gj < G; gj++) begin : g_bit
                if (gi * G + gj < N) begin : g_live
                    assign slice[gj] = in_votes[gi*G+gj];
                end else begin : g_pad
                    assign slice[gj] = 1'b0;
                end
            end
            popcnt_grp #(.G(G)) u_popcnt (
                .bits  (slice),
                .count (grp_cnt[gi])
            );
        end
    endgenerate

    // Stage 2 combinational: sum never overflows CW because N <= 2^CW - 1.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NG; i++) begin
            sum_next = sum_next + CW'(s1_cnt_reg[i]);
        end
        dbl_next = {sum_next, 1'b0};
        x_next   = (sum_next >= s1_thr_reg);
        tie_next = ((N % 2) == 0) && (dbl_next == CW1'(N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_thr_reg    <= '0;
            for (int i = 0; i < NG; i++) begin
                s1_cnt_reg[i] <= '0;
            end
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_x_reg     <= 1'b0;
            out_tie_reg   <= 1'b0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_thr_reg <= in_thr;
                for (int i = 0; i < NG; i++) begin
                    s1_cnt_reg[i] <= grp_cnt[i];
                end
            end
            out_valid_reg <= s1_valid_reg;
            // Payload only changes when a real transaction moves in, so a
            // bubble leaves the last result visible but marked invalid.
            if (s1_valid_reg) begin
                out_count_reg <= sum_next;
                out_x_reg     <= x_next;
                out_tie_reg   <= tie_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign out_x     = out_x_reg;
    assign out_tie   = out_tie_reg;

endmodule : maj_vote_pipe

// File: tb/tb_maj_vote_pipe.sv
// tb_maj_vote_pipe: directed + randomized bench for maj_vote_pipe.
//   u9 : default N=9, G=3     u8 : N=8, G=3 (short remainder group)
// Expected results come from a counting model and a per-instance queue.
module tb_maj_vote_pipe;

    localparam int N9 = 9;
    localparam int N8 = 8;
    localparam int GG = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       iv9, ir9, ov9, or9, ox9, ot9;
    logic [8:0] vt9;
    logic [3:0] th9, oc9;
    logic       iv8, ir8, ov8, or8, ox8, ot8;
    logic [7:0] vt8;
    logic [3:0] th8, oc8;

    typedef struct {
        int count;
        bit x;
        bit tie;
    } exp_t;

    exp_t q9[$];
    exp_t q8[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic last_acc9;

    always #5 clk = ~clk;

    maj_vote_pipe #(.N(N9), .G(GG)) u9 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv9), .in_ready(ir9),
        .in_votes(vt9), .in_thr(th9), .out_valid(ov9), .out_ready(or9),
        .out_count(oc9), .out_x(ox9), .out_tie(ot9)
    );

    maj_vote_pipe #(.N(N8), .G(GG)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .in_votes(vt8), .in_thr(th8), .out_valid(ov8), .out_ready(or8),
        .out_count(oc8), .out_x(ox8), .out_tie(ot8)
    );

    function automatic exp_t ref_eval(input logic [31:0] votes, input int thr, input int n);
        exp_t e;
        e.count = 0;
        for (int i = 0; i < n; i++) begin
            if (votes[i]) e.count++;
        end
        e.x   = (e.count >= thr);
        e.tie = ((n % 2) == 0) && (2 * e.count == n);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes, update scoreboards, advance, then check
    // output stability under stall and the in_ready rule.
    task automatic cycle();
        logic       acc9, acc8, pop9, pop8, st9, st8;
        logic [3:0] hc9, hc8;
        logic       hx9, hx8, ht9, ht8;
        exp_t       e;
        #1;
        acc9 = iv9 && ir9; pop9 = ov9 && or9; st9 = ov9 && !or9;
        acc8 = iv8 && ir8; pop8 = ov8 && or8; st8 = ov8 && !or8;
        hc9 = oc9; hx9 = ox9; ht9 = ot9;
        hc8 = oc8; hx8 = ox8; ht8 = ot8;
        if (pop9) begin
            if (q9.size() == 0) chk("spurious_out9", ov9, 0);
            else begin
                e = q9.pop_front();
                chk("count9", oc9, e.count);
                chk("x9", ox9, e.x);
                chk("tie9", ot9, e.tie);
            end
        end
        if (acc9) q9.push_back(ref_eval(32'(vt9), int'(th9), N9));
        if (pop8) begin
            if (q8.size() == 0) chk("spurious_out8", ov8, 0);
            else begin
                e = q8.pop_front();
                chk("count8", oc8, e.count);
                chk("x8", ox8, e.x);
                chk("tie8", ot8, e.tie);
            end
        end
        if (acc8) q8.push_back(ref_eval(32'(vt8), int'(th8), N8));
        last_acc9 = acc9;
        @(posedge clk);
        #1;
        if (st9) begin
            chk("hold_valid9", ov9, 1);
            chk("hold_count9", oc9, hc9);
            chk("hold_x9", ox9, hx9);
            chk("hold_tie9", ot9, ht9);
        end
        if (st8) begin
            chk("hold_valid8", ov8, 1);
            chk("hold_count8", oc8, hc8);
            chk("hold_x8", ox8, hx8);
            chk("hold_tie8", ot8, ht8);
        end
        chk("in_ready9", ir9, (!ov9 || or9));
        chk("in_ready8", ir8, (!ov8 || or8));
    endtask

    task automatic drain();
        iv9 = 0; iv8 = 0; or9 = 1; or8 = 1;
        for (int i = 0; i < 8 && (q9.size() > 0 || q8.size() > 0 || ov9 || ov8); i++) begin
            cycle();
        end
        chk("drain_q9", q9.size(), 0);
        chk("drain_q8", q8.size(), 0);
        chk("drain_ov9", ov9, 0);
        chk("drain_ov8", ov8, 0);
    endtask

    // Single transaction on an idle pipe with explicit 2-cycle latency check.
    task automatic single(input bit w8, input logic [8:0] v, input logic [3:0] t,
                          input int ec, input bit ex, input bit et);
        if (w8) begin iv8 = 1; vt8 = v[7:0]; th8 = t; end
        else    begin iv9 = 1; vt9 = v;      th9 = t; end
        cycle();
        iv8 = 0; iv9 = 0;
        chk("lat1_valid", w8 ? ov8 : ov9, 0);
        cycle();
        chk("lat2_valid", w8 ? ov8 : ov9, 1);
        chk("dir_count",  w8 ? oc8 : oc9, ec);
        chk("dir_x",      w8 ? ox8 : ox9, ex);
        chk("dir_tie",    w8 ? ot8 : ot9, et);
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        bit  pat[7] = '{1, 0, 1, 0, 1, 0, 0};
        iv9 = 0; vt9 = '0; th9 = '0; or9 = 1;
        iv8 = 0; vt8 = '0; th8 = '0; or8 = 1;
        last_acc9 = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov9", ov9, 0); chk("rst_oc9", oc9, 0);
        chk("rst_ox9", ox9, 0); chk("rst_ot9", ot9, 0);
        chk("rst_ov8", ov8, 0); chk("rst_oc8", oc8, 0);
        rst_n = 1;
        cycle();
        chk("rst_ir9", ir9, 1);

        single(0, 9'b000011111, 4'd5, 5, 1, 0);
        single(0, 9'b000001111, 4'd5, 4, 0, 0);
        single(0, 9'h000, 4'd0, 0, 1, 0);
        single(0, 9'h1FF, 4'd10, 9, 0, 0);
        single(1, 9'b011110000, 4'd5, 4, 0, 1);

        // Back-pressure: out_ready 1,0,0,1 repeating, six transactions.
        sent = 0;
        for (int c = 0; c < 40 && (sent < 6 || q9.size() > 0 || ov9); c++) begin
            or9 = ((c % 4) == 0) || ((c % 4) == 3);
            iv9 = (sent < 6);
            vt9 = 9'($urandom);
            th9 = 4'($urandom_range(0, 10));
            cycle();
            if (last_acc9) sent++;
        end
        chk("bp_sent", sent, 6);
        chk("bp_empty", q9.size(), 0);
        drain();

        // Randomized traffic on the remainder-group instance.
        for (int c = 0; c < 60; c++) begin
            iv8 = 1'($urandom_range(0, 1));
            or8 = ($urandom_range(0, 3) != 0);
            vt8 = 8'($urandom);
            th8 = 4'($urandom_range(0, 9));
            cycle();
        end
        drain();

        // Reset with two transactions in flight.
        iv9 = 1; vt9 = 9'h0F3; th9 = 4'd3;
        cycle();
        vt9 = 9'h1C1;
        cycle();
        iv9 = 0;
        chk("pre_rst_ov9", ov9, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_ov9", ov9, 0); chk("mid_rst_oc9", oc9, 0);
        chk("mid_rst_ox9", ox9, 0); chk("mid_rst_ot9", ot9, 0);
        q9.delete();
        q8.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("post_rst_ov9", ov9, 0);
        end
        single(0, 9'b101010101, 4'd4, 5, 1, 0);

        // Bubbles: out_valid follows in_valid two cycles later.
        drain();
        for (int t = 0; t < 7; t++) begin
            iv9 = pat[t];
            vt9 = 9'($urandom);
            th9 = 4'($urandom_range(0, 10));
            cycle();
            chk("bubble_ov9", ov9, (t >= 1) ? pat[t-1] : 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_maj_vote_pipe
